axis_accumulator: RTL and testbench
===================================

AXIS_ACCUMULATOR -- requirements
Module: axis_accumulator

Interface
REQ-001 SHALL have parameter MSAMPLE_WIDTH, default 16, width of one weighted input sample (8-bit sample x 8-bit weight).
REQ-002 SHALL have parameter SAMPLES, default 16, lanes per beat.
REQ-003 SHALL have parameter ACC_BEATS, default 4, beats summed per output; power of two, range 2..256.
REQ-004 SHALL have parameter ACC_WIDTH, default MSAMPLE_WIDTH+log2(ACC_BEATS) (=18), output lane width.
REQ-005 SHALL have port CLK  input  1  clock, all logic on rising edge.
REQ-006 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port s_axis_tdata  input  SAMPLES*MSAMPLE_WIDTH  unsigned weighted samples, lane i at [i*MSAMPLE_WIDTH +: MSAMPLE_WIDTH].
REQ-008 SHALL have port s_axis_tkeep  input  SAMPLES  per-lane valid mask.
REQ-009 SHALL have ports s_axis_tvalid input 1, s_axis_tready output 1, s_axis_tlast input 1  AXI-Stream slave handshake and end-of-packet.
REQ-010 SHALL have port m_axis_tdata  output  SAMPLES*ACC_WIDTH  per-lane sums, lane i at [i*ACC_WIDTH +: ACC_WIDTH].
REQ-011 SHALL have port m_axis_tkeep  output  SAMPLES  all ones while m_axis_tvalid=1, else zero.
REQ-012 SHALL have ports m_axis_tvalid output 1, m_axis_tready input 1, m_axis_tlast output 1  AXI-Stream master handshake.

Function
REQ-013 SHALL define an accepted input beat as s_axis_tvalid=1 and s_axis_tready=1 on a rising edge.
REQ-014 SHALL drive s_axis_tready = (m_axis_tvalid=0) or (m_axis_tready=1), combinationally, so one closing beat per cycle can stream without bubbles.
REQ-015 SHALL zero-extend each lane to ACC_WIDTH and treat lanes with s_axis_tkeep[i]=0 as zero.
REQ-016 SHALL keep a beat counter cnt (0..ACC_BEATS-1) and per-lane accumulator acc; both zero at group start.
REQ-017 SHALL, on an accepted non-closing beat, set acc <= acc + lane and cnt <= cnt+1.
REQ-018 SHALL treat a beat as closing when cnt=ACC_BEATS-1 or s_axis_tlast=1.
REQ-019 SHALL, on an accepted closing beat, load m_axis_tdata <= acc + lane, m_axis_tlast <= s_axis_tlast, m_axis_tvalid <= 1, acc <= 0, cnt <= 0.
REQ-020 SHALL present the output exactly one cycle after the closing beat (latency 1).
REQ-021 SHALL implement a two-state FSM: EMPTY (m_axis_tvalid=0) and FULL (m_axis_tvalid=1).
REQ-022 SHALL transition EMPTY->FULL on a closing beat; FULL->EMPTY on m_axis_tready=1 with no closing beat; FULL->FULL on m_axis_tready=1 with a simultaneous closing beat (new result replaces old).
REQ-023 SHALL hold m_axis_tdata, m_axis_tlast and m_axis_tvalid stable in FULL while m_axis_tready=0.
REQ-024 SHALL never wrap a sum: ACC_WIDTH guarantees ACC_BEATS x (2^MSAMPLE_WIDTH-1) fits.
REQ-025 SHALL output a partial sum (fewer than ACC_BEATS beats) when tlast closes early; the next group restarts at cnt=0.
REQ-026 SHALL leave acc and cnt unchanged on cycles without an accepted beat.

Reset
REQ-027 SHALL, while resetn=0 at a rising edge, clear acc, cnt, m_axis_tdata, m_axis_tkeep, m_axis_tlast and m_axis_tvalid to zero and enter EMPTY.
REQ-028 SHALL discard any partial group and pending output on reset mid-operation; s_axis_tready SHALL read 1 on the first cycle after reset release.

Structure
REQ-029 SHALL take MSAMPLE_WIDTH, SAMPLES and the FSM state encoding from the shared multiplier-chain package, so the multiplier output and this block's input agree.
REQ-030 SHALL use one sub-module, acc_lane, instantiated SAMPLES times, holding one lane's masked add and accumulator register; counter, FSM and handshake SHALL live in the top.

Verification
REQ-031 SHALL verify: 4 back-to-back beats, all lanes 16'd1000, tkeep all ones, m_tready=1 -> one output, every lane 18'd4000, tvalid one cycle after beat 4, tlast=0.
REQ-032 SHALL verify: 4 beats, all lanes 16'hFFFF -> every lane 18'd262140, no overflow.
REQ-033 SHALL verify: tlast=1 on beat 2 with lanes 5 then 7 -> lane sum 12, m_axis_tlast=1; the following 4 beats of 1 -> sum 4.
REQ-034 SHALL verify: m_tready=0 for 10 cycles after an output -> tvalid/tdata held, s_tready=0, no input consumed; m_tready=1 -> transfer and s_tready=1 the same cycle.
REQ-035 SHALL verify: tkeep=16'h00FF, all lanes 16'd10, 4 beats -> lanes 0-7 = 40, lanes 8-15 = 0.
REQ-036 SHALL verify: resetn=0 after 2 beats of a group -> outputs zero; 4 fresh beats of 3 after release -> sum 12, with no contribution from the pre-reset beats.

Source files
------------

// File: rtl/axis_accumulator_pkg.sv
// Shared multiplier-chain definitions: weighted-sample geometry and the
// output-stage FSM encoding used by the accumulator.
package axis_accumulator_pkg;

  localparam int MSAMPLE_W = 16;  // 8-bit sample x 8-bit weight
  localparam int N_SAMPLES = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } acc_state_e;

  // Lane width that cannot overflow after summing `beats` full-scale samples
  function automatic int acc_width(input int mw, input int beats);
    return mw + $clog2(beats);
  endfunction

endpackage

// File: rtl/axis_accumulator_lane.sv
// One accumulator lane: masked zero-extend, running sum, and the combinational
// sum including the current beat (loaded into the output register by the top).
module acc_lane
  import axis_accumulator_pkg::*;
#(
  parameter int MSAMPLE_WIDTH = MSAMPLE_W,
  parameter int ACC_WIDTH     = acc_width(MSAMPLE_W, 4)
) (
  input  logic                     CLK,
  input  logic                     resetn,
  input  logic [MSAMPLE_WIDTH-1:0] sample_i,
  input  logic                     keep_i,
  input  logic                     accept_i,
  input  logic                     close_i,
  output logic [ACC_WIDTH-1:0]     sum_o
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] lane;

  assign lane  = keep_i ? ACC_WIDTH'(sample_i) : '0;
  assign sum_o = acc_q + lane;

  // A closing beat hands its sum to the output stage and restarts the group
  always_comb begin
    acc_d = acc_q;
    if (accept_i) acc_d = close_i ? '0 : sum_o;
  end

  always_ff @(posedge CLK) begin
    if (!resetn) acc_q <= '0;
    else         acc_q <= acc_d;
  end

endmodule

// File: rtl/axis_accumulator.sv
// AXI-Stream accumulator: sums ACC_BEATS beats (or fewer on tlast) per lane and
// emits one result beat through a single-entry output register.
module axis_accumulator
  import axis_accumulator_pkg::*;
#(
  parameter int MSAMPLE_WIDTH = MSAMPLE_W,
  parameter int SAMPLES       = N_SAMPLES,
  parameter int ACC_BEATS     = 4,
  parameter int ACC_WIDTH     = acc_width(MSAMPLE_WIDTH, ACC_BEATS)
) (
  input  logic                           CLK,
  input  logic                           resetn,
  input  logic [SAMPLES*MSAMPLE_WIDTH-1:0] s_axis_tdata,
  input  logic [SAMPLES-1:0]             s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  output logic [SAMPLES*ACC_WIDTH-1:0]   m_axis_tdata,
  output logic [SAMPLES-1:0]             m_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast
);

  localparam int CNT_W = (ACC_BEATS > 1) ? $clog2(ACC_BEATS) : 1;

  if ((ACC_BEATS < 2) || (ACC_BEATS > 256) || ((ACC_BEATS & (ACC_BEATS - 1)) != 0))
    $error("ACC_BEATS must be a power of two in 2..256");

  acc_state_e                          state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [SAMPLES-1:0][ACC_WIDTH-1:0]   sum;
  logic [SAMPLES-1:0][ACC_WIDTH-1:0]   tdata_q, tdata_d;
  logic                                tlast_q, tlast_d;
  logic                                accept, closing, fire;

  // Output register frees up in the same cycle it is drained
  assign s_axis_tready = (state_q == ST_EMPTY) || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign closing       = (cnt_q == CNT_W'(ACC_BEATS - 1)) || s_axis_tlast;
  assign fire          = accept && closing;

  for (genvar i = 0; i < SAMPLES; i++) begin : g_lane
    acc_lane #(
      .MSAMPLE_WIDTH (MSAMPLE_WIDTH),
      .ACC_WIDTH     (ACC_WIDTH)
    ) u_lane (
      .CLK      (CLK),
      .resetn   (resetn),
      .sample_i (s_axis_tdata[i*MSAMPLE_WIDTH +: MSAMPLE_WIDTH]),
      .keep_i   (s_axis_tkeep[i]),
      .accept_i (accept),
      .close_i  (closing),
      .sum_o    (sum[i])
    );
  end

  always_comb begin
    state_d = state_q;
    tdata_d = tdata_q;
    tlast_d = tlast_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_EMPTY: if (fire) state_d = ST_FULL;
      ST_FULL: begin
        if (fire)               state_d = ST_FULL;
        else if (m_axis_tready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (fire) begin
      tdata_d = sum;
      tlast_d = s_axis_tlast;
    end
    if (accept) cnt_d = closing ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
      tdata_q <= '0;
      tlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tdata_q <= tdata_d;
      tlast_q <= tlast_d;
    end
  end

  assign m_axis_tvalid = (state_q == ST_FULL);
  assign m_axis_tkeep  = {SAMPLES{m_axis_tvalid}};
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_accumulator.sv
// Randomized + directed bench for axis_accumulator with a group-level reference model.
module tb_axis_accumulator;

  localparam int MW = 16;
  localparam int NS = 16;
  localparam int AB = 4;
  localparam int AW = MW + $clog2(AB);
  localparam int BW = NS * AW;

  typedef logic [NS-1:0][MW-1:0] beat_t;

  logic              CLK = 1'b0;
  logic              resetn;
  logic [NS*MW-1:0]  s_axis_tdata;
  logic [NS-1:0]     s_axis_tkeep;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic [BW-1:0]     m_axis_tdata;
  logic [NS-1:0]     m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;

  axis_accumulator #(
    .MSAMPLE_WIDTH (MW),
    .SAMPLES       (NS),
    .ACC_BEATS     (AB),
    .ACC_WIDTH     (AW)
  ) dut (
    .CLK           (CLK),
    .resetn        (resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 CLK = ~CLK;

  int nchk  = 0;
  int npass = 0;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
  endtask

  // Model: the accepted beats of the open group, plus the pending result
  beat_t         grp[$];
  logic          exp_valid = 1'b0;
  logic          exp_last  = 1'b0;
  logic [BW-1:0] exp_flat  = '0;

  always @(posedge CLK) begin
    beat_t b;
    longint s;
    logic  take;
    if (!resetn) begin
      exp_valid = 1'b0;
      exp_last  = 1'b0;
      grp.delete();
    end else begin
      take = s_axis_tvalid && (!exp_valid || m_axis_tready);
      if (exp_valid && m_axis_tready) exp_valid = 1'b0;
      if (take) begin
        for (int l = 0; l < NS; l++)
          b[l] = s_axis_tkeep[l] ? s_axis_tdata[l*MW +: MW] : '0;
        grp.push_back(b);
        if (grp.size() == AB || s_axis_tlast) begin
          for (int l = 0; l < NS; l++) begin
            s = 0;
            foreach (grp[k]) s += longint'(grp[k][l]);
            exp_flat[l*AW +: AW] = AW'(s);
          end
          exp_valid = 1'b1;
          exp_last  = s_axis_tlast;
          grp.delete();
        end
      end
    end
  end

  bit run_cmp = 1'b0;
  always @(negedge CLK) begin
    if (run_cmp) begin
      chk("m_tvalid", BW'(m_axis_tvalid), BW'(exp_valid));
      chk("s_tready", BW'(s_axis_tready), BW'(!exp_valid || m_axis_tready));
      chk("m_tkeep", BW'(m_axis_tkeep), exp_valid ? BW'({NS{1'b1}}) : '0);
      if (exp_valid) begin
        chk("m_tdata", m_axis_tdata, exp_flat);
        chk("m_tlast", BW'(m_axis_tlast), BW'(exp_last));
      end
    end
  end

  function automatic logic [BW-1:0] fill(input int v, input logic [NS-1:0] k);
    logic [BW-1:0] r = '0;
    for (int l = 0; l < NS; l++) if (k[l]) r[l*AW +: AW] = AW'(v);
    return r;
  endfunction

  task automatic beat(input logic [MW-1:0] v, input logic [NS-1:0] k, input logic l);
    for (int i = 0; i < NS; i++) s_axis_tdata[i*MW +: MW] = v;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    @(posedge CLK); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  initial begin
    resetn = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    idle(3);
    run_cmp = 1'b1;
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_tvalid", BW'(m_axis_tvalid), '0);
    chk("rst_tlast", BW'(m_axis_tlast), '0);
    resetn = 1'b1;
    #1 chk("rel_s_tready", BW'(s_axis_tready), BW'(1));
    idle(1);

    // four beats of 1000
    repeat (3) beat(16'd1000, '1, 1'b0);
    chk("b2b_early_tvalid", BW'(m_axis_tvalid), '0);
    beat(16'd1000, '1, 1'b0);
    chk("b2b_tvalid", BW'(m_axis_tvalid), BW'(1));
    chk("b2b_4000", m_axis_tdata, fill(4000, '1));
    chk("b2b_tlast", BW'(m_axis_tlast), '0);
    idle(1);
    chk("b2b_drained", BW'(m_axis_tvalid), '0);

    // full scale
    repeat (4) beat(16'hFFFF, '1, 1'b0);
    chk("max_262140", m_axis_tdata, fill(262140, '1));
    idle(1);

    // early tlast, then a fresh full group
    beat(16'd5, '1, 1'b0);
    beat(16'd7, '1, 1'b1);
    chk("tlast_sum12", m_axis_tdata, fill(12, '1));
    chk("tlast_flag", BW'(m_axis_tlast), BW'(1));
    repeat (4) beat(16'd1, '1, 1'b0);
    chk("after_tlast_sum4", m_axis_tdata, fill(4, '1));
    chk("after_tlast_flag", BW'(m_axis_tlast), '0);
    idle(1);

    // backpressure holds result and blocks input
    m_axis_tready = 1'b0;
    repeat (4) beat(16'd2, '1, 1'b0);
    for (int i = 0; i < NS; i++) s_axis_tdata[i*MW +: MW] = 16'd77;
    s_axis_tkeep = '1; s_axis_tvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("bp_tvalid", BW'(m_axis_tvalid), BW'(1));
      chk("bp_tdata", m_axis_tdata, fill(8, '1));
      chk("bp_s_tready", BW'(s_axis_tready), '0);
      idle(1);
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    #1 chk("bp_release_s_tready", BW'(s_axis_tready), BW'(1));
    idle(1);
    chk("bp_transferred", BW'(m_axis_tvalid), '0);

    // partial keep mask
    repeat (4) beat(16'd10, 16'h00FF, 1'b0);
    chk("keep_mask", m_axis_tdata, fill(40, 16'h00FF));
    idle(1);

    // reset mid-group
    repeat (2) beat(16'd9, '1, 1'b0);
    resetn = 1'b0;
    idle(1);
    chk("midrst_tdata", m_axis_tdata, '0);
    chk("midrst_tvalid", BW'(m_axis_tvalid), '0);
    chk("midrst_tkeep", BW'(m_axis_tkeep), '0);
    resetn = 1'b1;
    #1 chk("midrst_s_tready", BW'(s_axis_tready), BW'(1));
    idle(1);
    repeat (4) beat(16'd3, '1, 1'b0);
    chk("midrst_sum12", m_axis_tdata, fill(12, '1));
    idle(1);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NS; i++) s_axis_tdata[i*MW +: MW] = MW'($urandom);
      s_axis_tkeep  = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '1;
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tlast  = ($urandom_range(0, 7) == 0);
      m_axis_tready = ($urandom_range(0, 9) < 7);
      resetn        = ($urandom_range(0, 499) != 0);
      @(posedge CLK); #1;
    end
    resetn = 1'b1; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    idle(3);
    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
